// File: rtl/ppi_bus_master.sv
// ppi_bus_master: single-transaction parallel peripheral bus master with
// programmable setup/strobe/hold timing; every output is a flop.
`default_nettype none

module ppi_bus_master #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clock,
  input  logic       reset_in,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_address,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic [1:0] address,
  output logic [7:0] data_bus_out,
  output logic       data_bus_oe,
  input  logic [7:0] data_bus_in
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

  state_t     state_q;
  logic [3:0] phase_q;
  logic       write_q;
  logic       req_ready_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       cs_n_q;
  logic       re_n_q;
  logic       we_n_q;
  logic [1:0] address_q;
  logic [7:0] dout_q;
  logic       oe_q;

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= IDLE;
      phase_q     <= 4'd0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'd0;
      cs_n_q      <= 1'b1;
      re_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      address_q   <= 2'd0;
      dout_q      <= 8'd0;
      oe_q        <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // req_ready rises one edge after reset release or DONE
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (req_valid) begin
            req_ready_q <= 1'b0;
            write_q     <= req_write;
            address_q   <= req_address;
            dout_q      <= req_wdata;
            oe_q        <= req_write;
            cs_n_q      <= 1'b0;
            phase_q     <= SETUP_LOAD;
            state_q     <= SETUP;
          end
        end
        SETUP: begin
          if (phase_q == 4'd0) begin
            re_n_q  <= write_q;
            we_n_q  <= ~write_q;
            phase_q <= STROBE_LOAD;
            state_q <= STROBE;
          end else begin
            phase_q <= phase_q - 4'd1;
          end
        end
        STROBE: begin
          if (phase_q == 4'd0) begin
            re_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            if (!write_q) begin
              rsp_rdata_q <= data_bus_in;
            end
            phase_q <= HOLD_LOAD;
            state_q <= HOLD;
          end else begin
            phase_q <= phase_q - 4'd1;
          end
        end
        HOLD: begin
          if (phase_q == 4'd0) begin
            cs_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            phase_q <= phase_q - 4'd1;
          end
        end
        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign chip_select_n  = cs_n_q;
  assign read_enable_n  = re_n_q;
  assign write_enable_n = we_n_q;
  assign address        = address_q;
  assign data_bus_out   = dout_q;
  assign data_bus_oe    = oe_q;

endmodule

`default_nettype wire
